// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store/copy engine in front of a registered-read data memory.
// Requests are captured in IDLE; memory strobes are decoded from registered state only.
module mem_access_unit #(
  parameter int MEM_BASE = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_dst,
  input  logic [3:0] req_len,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_err,
  output logic       busy,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_ADDR = 3'd1;
  localparam logic [2:0] S_LD_WAIT = 3'd2;
  localparam logic [2:0] S_ST      = 3'd3;
  localparam logic [2:0] S_CP_RD   = 3'd4;
  localparam logic [2:0] S_CP_WAIT = 3'd5;
  localparam logic [2:0] S_CP_WR   = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  localparam logic [7:0] BASE = MEM_BASE[7:0];

  logic [2:0] state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] dst_q, dst_d;
  logic [3:0] len_q, len_d;
  logic [7:0] wdata_q, wdata_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_err_q, resp_err_d;
  logic [7:0] resp_data_q, resp_data_d;

  logic [8:0] src_end;
  logic [8:0] dst_end;
  logic       req_bad;

  // Range ends are formed at 9 bits so a copy wrapping past 0xFF is caught.
  always_comb begin
    src_end = {1'b0, req_addr} + {5'b0, req_len};
    dst_end = {1'b0, req_dst} + {5'b0, req_len};
    req_bad = 1'b0;
    case (req_op)
      2'b00, 2'b01: req_bad = (req_addr < BASE);
      2'b10:        req_bad = (req_addr < BASE) || (req_dst < BASE) ||
                              (src_end > 9'd255) || (dst_end > 9'd255);
      default:      req_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    dst_d        = dst_q;
    len_d        = len_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          dst_d   = req_dst;
          len_d   = req_len;
          wdata_d = req_wdata;
          idx_d   = 4'd0;
          if (req_bad)              state_d = S_ERR;
          else if (req_op == 2'b00) state_d = S_LD_ADDR;
          else if (req_op == 2'b01) state_d = S_ST;
          else                      state_d = S_CP_RD;
        end
      end
      S_LD_ADDR: state_d = S_LD_WAIT;
      S_LD_WAIT: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = mem_rdata;
        state_d      = S_IDLE;
      end
      S_ST: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = 8'h00;
        state_d      = S_IDLE;
      end
      S_CP_RD: state_d = S_CP_WAIT;
      S_CP_WAIT: begin
        hold_d  = mem_rdata;
        state_d = S_CP_WR;
      end
      S_CP_WR: begin
        if (idx_q == len_q) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = hold_q;
          state_d      = S_IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_CP_RD;
        end
      end
      default: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_data_d  = 8'h00;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= 8'h00;
      dst_q        <= 8'h00;
      len_q        <= 4'h0;
      wdata_q      <= 8'h00;
      idx_q        <= 4'h0;
      hold_q       <= 8'h00;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  always_comb begin
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    case (state_q)
      S_LD_ADDR: mem_addr = addr_q;
      S_ST: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b1;
      end
      S_CP_RD: mem_addr = addr_q + {4'b0, idx_q};
      S_CP_WR: begin
        mem_addr  = dst_q + {4'b0, idx_q};
        mem_wdata = hold_q;
        mem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = ~req_ready;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table and sequence checks for mem_access_unit.
module tb_mem_access_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_dst;
  logic [3:0] req_len;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_err;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];
  logic       mem_clr;
  logic       bk_we;
  logic [7:0] bk_addr;
  logic [7:0] bk_data;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_unit #(.MEM_BASE(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_dst(req_dst), .req_len(req_len),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Registered-read memory model with a side port for preloading.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (bk_we)  mem[bk_addr]  <= bk_data;
    end
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] dst;
    logic [3:0] len;
    logic [7:0] wdata;
    logic       exp_err;
    logic [7:0] exp_data;
    int         exp_lat;
    int         exp_we;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bk_addr = a;
    bk_data = d;
    bk_we   = 1'b1;
    @(posedge clk); #1;
    bk_we   = 1'b0;
  endtask

  task automatic run_req(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] dst,
                         input logic [3:0] len, input logic [7:0] wdata,
                         output int lat, output int we_cnt, output logic [63:0] we_seq);
    req_op = op; req_addr = addr; req_dst = dst; req_len = len; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; we_cnt = 0; we_seq = '0;
    for (int k = 1; k <= 200; k++) begin
      we_seq = {we_seq[62:0], mem_we};
      we_cnt += int'(mem_we);
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  int          lat, we_cnt;
  logic [63:0] we_seq;
  logic        saw_resp;

  initial begin
    vecs[0]  = '{2'b01, 8'h80, 8'h00, 4'd0,  8'hA5, 1'b0, 8'h00, 1, 1};
    vecs[1]  = '{2'b00, 8'h80, 8'h00, 4'd0,  8'h00, 1'b0, 8'hA5, 2, 0};
    vecs[2]  = '{2'b00, 8'h3F, 8'h00, 4'd0,  8'h00, 1'b1, 8'h00, 1, 0};
    vecs[3]  = '{2'b11, 8'h80, 8'h90, 4'd0,  8'h00, 1'b1, 8'h00, 1, 0};
    vecs[4]  = '{2'b10, 8'hF8, 8'h80, 4'd15, 8'h00, 1'b1, 8'h00, 1, 0};
    vecs[5]  = '{2'b01, 8'h40, 8'h00, 4'd0,  8'h3C, 1'b0, 8'h00, 1, 1};
    vecs[6]  = '{2'b00, 8'h40, 8'h00, 4'd0,  8'h00, 1'b0, 8'h3C, 2, 0};
    vecs[7]  = '{2'b01, 8'hFF, 8'h00, 4'd0,  8'h77, 1'b0, 8'h00, 1, 1};
    vecs[8]  = '{2'b00, 8'hFF, 8'h00, 4'd0,  8'h00, 1'b0, 8'h77, 2, 0};
    vecs[9]  = '{2'b01, 8'h3F, 8'h00, 4'd0,  8'h12, 1'b1, 8'h00, 1, 0};
    vecs[10] = '{2'b10, 8'h80, 8'hF8, 4'd8,  8'h00, 1'b1, 8'h00, 1, 0};
    vecs[11] = '{2'b10, 8'h80, 8'h10, 4'd0,  8'h00, 1'b1, 8'h00, 1, 0};
    vecs[12] = '{2'b10, 8'h80, 8'hFE, 4'd1,  8'h00, 1'b0, 8'h00, 6, 2};

    rst_n = 1'b0; mem_clr = 1'b1; bk_we = 1'b0; bk_addr = 8'h00; bk_data = 8'h00;
    req_valid = 1'b0; req_op = 2'b00; req_addr = 8'h00; req_dst = 8'h00;
    req_len = 4'h0; req_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1; mem_clr = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", req_ready, 1);

    for (int i = 0; i < 13; i++) begin
      chk($sformatf("v%0d_ready", i), req_ready, 1);
      run_req(vecs[i].op, vecs[i].addr, vecs[i].dst, vecs[i].len, vecs[i].wdata, lat, we_cnt, we_seq);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_err", i), resp_err, vecs[i].exp_err);
      chk($sformatf("v%0d_data", i), resp_data, vecs[i].exp_data);
      chk($sformatf("v%0d_we_cnt", i), we_cnt, vecs[i].exp_we);
      chk($sformatf("v%0d_ready_at_resp", i), req_ready, 1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse", i), resp_valid, 0);
      chk($sformatf("v%0d_err_hold", i), resp_err, vecs[i].exp_err);
    end
    chk("mem_80", mem[8'h80], 8'hA5);
    chk("mem_3f_untouched", mem[8'h3F], 8'h00);
    chk("mem_fe", mem[8'hFE], 8'hA5);
    chk("mem_ff", mem[8'hFF], 8'h00);

    poke(8'h40, 8'h11); poke(8'h41, 8'h22); poke(8'h42, 8'h33); poke(8'h43, 8'h44);
    run_req(2'b10, 8'h40, 8'h90, 4'd3, 8'h00, lat, we_cnt, we_seq);
    chk("cp4_lat", lat, 12);
    chk("cp4_data", resp_data, 8'h44);
    chk("cp4_err", resp_err, 0);
    chk("cp4_we_seq", we_seq[11:0], 12'b001001001001);
    for (int i = 0; i < 4; i++) chk($sformatf("cp4_dst%0d", i), mem[8'h90 + i], 8'h11 * (i + 1));

    for (int i = 0; i < 16; i++) poke(8'hF0 + 8'(i), 8'hC0 + 8'(i));
    run_req(2'b10, 8'hF0, 8'h40, 4'd15, 8'h00, lat, we_cnt, we_seq);
    chk("cp16_lat", lat, 48);
    chk("cp16_err", resp_err, 0);
    chk("cp16_data", resp_data, 8'hCF);
    for (int i = 0; i < 16; i++) chk($sformatf("cp16_dst%0d", i), mem[8'h40 + i], 8'hC0 + 8'(i));

    poke(8'h50, 8'h07); poke(8'h51, 8'h09); poke(8'h52, 8'h00);
    run_req(2'b10, 8'h50, 8'h51, 4'd1, 8'h00, lat, we_cnt, we_seq);
    chk("ovl_lat", lat, 6);
    chk("ovl_data", resp_data, 8'h07);
    chk("ovl_51", mem[8'h51], 8'h07);
    chk("ovl_52", mem[8'h52], 8'h07);

    // A store offered while a load is in flight must be ignored.
    req_op = 2'b00; req_addr = 8'h90; req_valid = 1'b1;
    @(posedge clk); #1;
    req_op = 2'b01; req_wdata = 8'h00;
    chk("busy_in_load", busy, 1);
    chk("not_ready_in_load", req_ready, 0);
    @(posedge clk); #1;
    chk("ld_wait_addr", mem_addr, 8'h00);
    chk("ld_wait_we", mem_we, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ign_resp_valid", resp_valid, 1);
    chk("ign_resp_data", resp_data, 8'h11);
    @(posedge clk); #1;
    chk("ign_mem_90", mem[8'h90], 8'h11);

    for (int i = 0; i < 16; i++) poke(8'h60 + 8'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 16; i++) poke(8'hA0 + 8'(i), 8'hEE);
    req_op = 2'b10; req_addr = 8'h60; req_dst = 8'hA0; req_len = 4'd15; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_in_wr", mem_we, 1);
    chk("abort_wr_addr", mem_addr, 8'hA2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_busy", busy, 0);
    chk("abort_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_resp = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid) saw_resp = 1'b1;
    end
    chk("abort_no_resp", saw_resp, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_dst0", mem[8'hA0], 8'h10);
    chk("abort_dst1", mem[8'hA1], 8'h11);
    chk("abort_dst2", mem[8'hA2], 8'hEE);
    chk("abort_dst3", mem[8'hA3], 8'hEE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_BASE, default 64: lowest legal data memory address; legal range is MEM_BASE..255.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  request strobe.
REQ-005 req_ready  out  1  unit accepts a request; high only in IDLE.
REQ-006 req_op  in  2  00 load, 01 store, 10 copy, 11 reserved.
REQ-007 req_addr  in  8  load/store address; copy source base.
REQ-008 req_dst  in  8  copy destination base.
REQ-009 req_len  in  4  copy byte count minus one (1..16 bytes).
REQ-010 req_wdata  in  8  store data.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_data  out  8  load data, last copied byte, or 0.
REQ-013 resp_err  out  1  request rejected; qualified by resp_valid.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 mem_addr  out  8  data memory address.
REQ-016 mem_wdata  out  8  data memory write data.
REQ-017 mem_we  out  1  data memory write enable.
REQ-018 mem_rdata  in  8  data memory read data; registered: valid one edge after mem_addr is presented with mem_we=0.

Function
REQ-019 Acceptance occurs on a rising edge with req_valid=1 and req_ready=1 (edge E0); all req_* fields are captured into internal registers at E0.
REQ-020 States: IDLE, LD_ADDR, LD_WAIT, ST, CP_RD, CP_WAIT, CP_WR, ERR.
REQ-021 mem_addr/mem_wdata/mem_we are decoded only from registered state and operands; no combinational path from any req_* input.
REQ-022 mem_we is 1 only in ST and CP_WR; 0 in every other state.
REQ-023 In IDLE, LD_WAIT, CP_WAIT and ERR, mem_addr=0 and mem_wdata=0.
REQ-024 Load: IDLE->LD_ADDR at E0 (mem_addr=addr, mem_we=0); LD_ADDR->LD_WAIT at E1; at E2 resp_data<=mem_rdata, resp_valid<=1, resp_err<=0, state->IDLE.
REQ-025 Store: IDLE->ST at E0 (mem_addr=addr, mem_wdata=wdata, mem_we=1); at E1 resp_valid<=1, resp_data<=0, resp_err<=0, state->IDLE.
REQ-026 Copy, L=req_len+1, byte i=0..L-1 ascending: CP_RD (mem_addr=src+i, mem_we=0) -> CP_WAIT -> CP_WR (mem_addr=dst+i, mem_wdata=hold, mem_we=1); hold<=mem_rdata on leaving CP_WAIT.
REQ-027 Copy takes exactly 3 cycles per byte; after the write edge of byte L-1 (E3L): resp_valid<=1, resp_data<=byte L-1, resp_err<=0, state->IDLE.
REQ-028 Overlapping copy ranges are copied strictly byte by byte in ascending order; no overlap correction.
REQ-029 Error conditions, evaluated on captured fields: op=11; load/store addr<MEM_BASE; copy src<MEM_BASE or dst<MEM_BASE; copy src+req_len>255 or dst+req_len>255, computed at 9 bits.
REQ-030 On error: IDLE->ERR at E0, no memory access (mem_we=0 throughout); at E1 resp_valid<=1, resp_err<=1, resp_data<=0, state->IDLE.
REQ-031 resp_valid is high for exactly one cycle per accepted request; resp_data and resp_err hold their values until the next response.
REQ-032 req_ready is high in the same cycle resp_valid is high; a new request is accepted at the next edge.
REQ-033 req_valid while not in IDLE is ignored; it causes no capture and no state change.
REQ-034 busy equals the inverse of req_ready.

Reset
REQ-035 rst_n low immediately forces: state=IDLE, resp_valid=0, resp_err=0, resp_data=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, operand and hold registers=0.
REQ-036 Reset mid-operation aborts it with no response; bytes already written by a copy remain in memory; the aborted request is not resumed.
REQ-037 req_ready is 1 from the first cycle after rst_n deasserts.

Verification
REQ-038 Store then load: store 0xA5 to 0x80, then load 0x80 -> store resp at E1 with err=0; load resp at E2 with resp_data=0xA5; mem_we high exactly one cycle in total.
REQ-039 Copy: memory 0x40..0x43 = 11,22,33,44; copy src=0x40, dst=0x90, req_len=3 -> 0x90..0x93 = 11,22,33,44; resp at E12 with resp_data=0x44; mem_we pattern 001 repeating.
REQ-040 Errors: load 0x3F; op=11; copy src=0xF8, req_len=15 -> each gives resp_err=1 and resp_data=0 at E1; mem_we never asserted.
REQ-041 Boundary: copy src=0xF0, dst=0x40, req_len=15 is accepted and is not an error; bytes 0xF0..0xFF land at 0x40..0x4F.
REQ-042 Overlap: 0x50..0x51 = 7,9; copy src=0x50, dst=0x51, req_len=1 -> 0x51=7, 0x52=7.
REQ-043 Reset abort: assert rst_n during CP_WR of byte 2 of a 16-byte copy -> outputs go to reset values immediately; dst bytes 0..1 written, byte 2 and later unchanged; no resp_valid.
